// File: rtl/proc_pkg.sv
// Processor-wide constants and types shared by the decoder and issue logic.
package proc_pkg;

    localparam int unsigned ADDRESS_SIZE     = 32;
    localparam int unsigned REG_ADDRESS_SIZE = 5;
    localparam int unsigned NUM_REGS         = 32;

    typedef logic [REG_ADDRESS_SIZE-1:0] reg_addr_t;

endpackage : proc_pkg

// File: rtl/issue_scoreboard.sv
// Issue scoreboard: tracks registers with pending writes, blocks RAW/WAW
// hazards, caps in-flight writes and counts issue stalls.
// Optional feature: define SCOREBOARD_BYPASS_EN to let a register being
// retired by writeback this cycle count as free for the issuing instruction.
module issue_scoreboard #(
    parameter int unsigned NUM_REGS         = proc_pkg::NUM_REGS,
    parameter int unsigned REG_ADDRESS_SIZE = proc_pkg::REG_ADDRESS_SIZE,
    parameter int unsigned MAX_OUTSTANDING  = 8
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   issue_valid,
    input  logic [REG_ADDRESS_SIZE-1:0]            addr_r1,
    input  logic [REG_ADDRESS_SIZE-1:0]            addr_r2,
    input  logic [REG_ADDRESS_SIZE-1:0]            addr_rd,
    input  logic                                   register_write,
    output logic                                   issue_ready,
    input  logic                                   wb_valid,
    input  logic [REG_ADDRESS_SIZE-1:0]            wb_addr,
    input  logic                                   flush,
    output logic [NUM_REGS-1:0]                    busy_mask,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
    output logic [31:0]                            stall_count,
    output logic                                   wb_error
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
    localparam logic [31:0] STALL_SAT = 32'hFFFF_FFFF;

    // One-hot decode of a register address into the busy vector.
    function automatic logic [NUM_REGS-1:0] onehot(input logic [REG_ADDRESS_SIZE-1:0] a);
        onehot = NUM_REGS'(1) << a;
    endfunction

    logic                  wb_busy;
    logic                  wb_hit;
    logic                  wb_spurious;
    logic [NUM_REGS-1:0]   clr_vec;
    logic [NUM_REGS-1:0]   set_vec;
    logic [NUM_REGS-1:0]   look_busy;
    logic [CNT_W-1:0]      occupancy;
    logic                  rd_nonzero;
    logic                  hazard;
    logic                  full;
    logic                  fire;
    logic                  set_en;
    logic [NUM_REGS-1:0]   busy_d;
    logic [CNT_W-1:0]      outstanding_d;
    logic [31:0]           stall_count_d;
    logic                  wb_error_d;

    // Writeback classification: valid retire vs. spurious retire.
    always_comb begin
        wb_busy     = busy_mask[wb_addr];
        wb_hit      = wb_valid & wb_busy;
        wb_spurious = wb_valid & ~wb_busy & ~flush;
        clr_vec     = wb_hit ? onehot(wb_addr) : '0;
    end

    // State seen by the hazard and capacity checks.
`ifdef SCOREBOARD_BYPASS_EN
    always_comb begin
        look_busy = busy_mask & ~clr_vec;
        occupancy = outstanding - CNT_W'(wb_hit);
    end
`else
    always_comb begin
        look_busy = busy_mask;
        occupancy = outstanding;
    end
`endif

    // Issue decision: RAW/WAW hazards, write-slot capacity, flush and reset.
    always_comb begin
        rd_nonzero  = (addr_rd != '0);
        hazard      = look_busy[addr_r1] | look_busy[addr_r2]
                    | (register_write & look_busy[addr_rd]);
        full        = register_write & rd_nonzero & (occupancy == CNT_MAX);
        issue_ready = reset & ~hazard & ~full & ~flush;
        fire        = issue_valid & issue_ready;
        set_en      = fire & register_write & rd_nonzero;
        set_vec     = set_en ? onehot(addr_rd) : '0;
    end

    // Next-state for busy bits and the in-flight counter; set wins over clear.
    always_comb begin
        busy_d        = busy_mask;
        outstanding_d = outstanding;
        if (flush) begin
            busy_d        = '0;
            outstanding_d = '0;
        end else begin
            busy_d = (busy_mask & ~clr_vec) | set_vec;
            unique case ({set_en, wb_hit})
                2'b10:   outstanding_d = outstanding + CNT_W'(1);
                2'b01:   outstanding_d = outstanding - CNT_W'(1);
                default: outstanding_d = outstanding;
            endcase
        end
        busy_d[0] = 1'b0;
    end

    // Saturating stall counter and sticky spurious-writeback flag.
    always_comb begin
        stall_count_d = stall_count;
        wb_error_d    = wb_error | wb_spurious;
        if (issue_valid && !issue_ready && (stall_count != STALL_SAT)) begin
            stall_count_d = stall_count + 32'd1;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            busy_mask   <= '0;
            outstanding <= '0;
            stall_count <= '0;
            wb_error    <= 1'b0;
        end else begin
            busy_mask   <= busy_d;
            outstanding <= outstanding_d;
            stall_count <= stall_count_d;
            wb_error    <= wb_error_d;
        end
    end

endmodule : issue_scoreboard

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: vector table, directed corner
// sequences and randomized traffic against a register-set reference model.
module tb_issue_scoreboard;

    localparam int NR = 32;
    localparam int MO = 8;
`ifdef SCOREBOARD_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic [4:0]  addr_r1, addr_r2, addr_rd;
    logic        register_write;
    logic        issue_ready;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic        flush;
    logic [31:0] busy_mask;
    logic [3:0]  outstanding;
    logic [31:0] stall_count;
    logic        wb_error;

    always #5 clk = ~clk;

    issue_scoreboard #(.NUM_REGS(NR), .REG_ADDRESS_SIZE(5), .MAX_OUTSTANDING(MO)) dut (
        .clk(clk), .reset(reset), .issue_valid(issue_valid),
        .addr_r1(addr_r1), .addr_r2(addr_r2), .addr_rd(addr_rd),
        .register_write(register_write), .issue_ready(issue_ready),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .flush(flush),
        .busy_mask(busy_mask), .outstanding(outstanding),
        .stall_count(stall_count), .wb_error(wb_error)
    );

    // Reference model: set of registers awaiting writeback, plus counters.
    bit          m_busy [NR];
    int unsigned m_stall;
    bit          m_err;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < NR; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    function automatic logic [31:0] m_mask();
        logic [31:0] v = '0;
        for (int i = 0; i < NR; i++) v[i] = m_busy[i];
        return v;
    endfunction

    function automatic bit m_ready(input bit rw, input bit [4:0] r1, input bit [4:0] r2,
                                   input bit [4:0] rd, input bit wbv, input bit [4:0] wba,
                                   input bit fl, input bit rst_n);
        bit eb [NR];
        int freed = 0;
        for (int i = 0; i < NR; i++) eb[i] = m_busy[i];
        if (BYP && wbv && m_busy[wba]) begin
            eb[wba] = 1'b0;
            freed   = 1;
        end
        if (!rst_n || fl) return 1'b0;
        if (eb[r1] || eb[r2] || (rw && eb[rd])) return 1'b0;
        if (rw && rd != 0 && (m_count() - freed) == MO) return 1'b0;
        return 1'b1;
    endfunction

    task automatic m_update(input bit rdy, input bit iv, input bit rw, input bit [4:0] rd,
                            input bit wbv, input bit [4:0] wba, input bit fl, input bit rst_n);
        if (!rst_n) begin
            for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
            m_stall = 0;
            m_err   = 1'b0;
            return;
        end
        if (iv && !rdy && m_stall != 32'hFFFF_FFFF) m_stall++;
        if (fl) begin
            for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
        end else begin
            if (wbv) begin
                if (m_busy[wba]) m_busy[wba] = 1'b0;
                else             m_err       = 1'b1;
            end
            if (iv && rdy && rw && rd != 0) m_busy[rd] = 1'b1;
        end
    endtask

    // One clock: drive, check issue_ready, clock, check registered outputs.
    task automatic step(input bit iv, input bit [4:0] r1, input bit [4:0] r2, input bit [4:0] rd,
                        input bit rw, input bit wbv, input bit [4:0] wba, input bit fl,
                        input bit rst_n, output logic got_ready);
        bit exp_r;
        issue_valid = iv; addr_r1 = r1; addr_r2 = r2; addr_rd = rd;
        register_write = rw; wb_valid = wbv; wb_addr = wba; flush = fl; reset = rst_n;
        #1;
        exp_r     = m_ready(rw, r1, r2, rd, wbv, wba, fl, rst_n);
        got_ready = issue_ready;
        chk("issue_ready", 32'(issue_ready), 32'(exp_r));
        @(posedge clk);
        m_update(exp_r, iv, rw, rd, wbv, wba, fl, rst_n);
        #1;
        chk("busy_mask", busy_mask, m_mask());
        chk("outstanding", 32'(outstanding), 32'(m_count()));
        chk("stall_count", stall_count, m_stall);
        chk("wb_error", 32'(wb_error), 32'(m_err));
    endtask

    typedef struct {
        bit          iv;
        bit [4:0]    r1, r2, rd;
        bit          rw, wbv;
        bit [4:0]    wba;
        bit          fl;
        bit          exp_ready;
        logic [31:0] exp_busy;
        int          exp_out;
        bit          exp_err;
    } vec_t;

    function automatic vec_t mk(input bit iv, input bit [4:0] r1, input bit [4:0] r2,
                                input bit [4:0] rd, input bit rw, input bit wbv,
                                input bit [4:0] wba, input bit fl, input bit er,
                                input logic [31:0] eb, input int eo, input bit ee);
        vec_t v;
        v.iv = iv; v.r1 = r1; v.r2 = r2; v.rd = rd; v.rw = rw; v.wbv = wbv;
        v.wba = wba; v.fl = fl; v.exp_ready = er; v.exp_busy = eb; v.exp_out = eo; v.exp_err = ee;
        return v;
    endfunction

    vec_t tbl [15];
    logic gr;

    initial begin
        // issue, r1, r2, rd, rw, wbv, wba, flush | ready, busy, outstanding, wb_error
        tbl[0]  = mk(1, 0, 0, 3, 1, 0, 0, 0,   1,     32'h0000_0008, 1, 0);
        tbl[1]  = mk(1, 3, 0, 0, 0, 0, 0, 0,   0,     32'h0000_0008, 1, 0);
        tbl[2]  = mk(1, 3, 0, 0, 0, 1, 3, 0,   BYP,   32'h0000_0000, 0, 0);
        tbl[3]  = mk(1, 3, 0, 0, 0, 0, 0, 0,   1,     32'h0000_0000, 0, 0);
        tbl[4]  = mk(1, 0, 0, 5, 1, 0, 0, 0,   1,     32'h0000_0020, 1, 0);
        tbl[5]  = mk(1, 0, 0, 6, 1, 0, 0, 0,   1,     32'h0000_0060, 2, 0);
        tbl[6]  = mk(1, 0, 0, 7, 1, 1, 5, 1,   0,     32'h0000_0000, 0, 0);
        tbl[7]  = mk(1, 0, 0, 0, 1, 0, 0, 0,   1,     32'h0000_0000, 0, 0);
        tbl[8]  = mk(1, 0, 0, 0, 1, 0, 0, 0,   1,     32'h0000_0000, 0, 0);
        tbl[9]  = mk(1, 0, 0, 0, 1, 0, 0, 0,   1,     32'h0000_0000, 0, 0);
        tbl[10] = mk(0, 0, 0, 0, 0, 1, 0, 0,   1,     32'h0000_0000, 0, 1);
        tbl[11] = mk(1, 2, 2, 2, 1, 0, 0, 0,   1,     32'h0000_0004, 1, 1);
        tbl[12] = mk(1, 0, 0, 2, 1, 0, 0, 0,   0,     32'h0000_0004, 1, 1);
        tbl[13] = mk(1, 0, 0, 2, 0, 0, 0, 0,   1,     32'h0000_0004, 1, 1);
        tbl[14] = mk(0, 0, 0, 0, 0, 1, 2, 0,   1,     32'h0000_0000, 0, 1);

        issue_valid = 0; addr_r1 = 0; addr_r2 = 0; addr_rd = 0; register_write = 0;
        wb_valid = 0; wb_addr = 0; flush = 0; reset = 0;
        m_stall = 0; m_err = 0;
        for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
        @(posedge clk); #1;

        // Reset state, with issue_ready held low while in reset.
        step(1, 0, 0, 4, 1, 0, 0, 0, 0, gr);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, gr);
        chk("reset_ready", 32'(gr), 32'd0);
        chk("reset_busy", busy_mask, 32'd0);
        chk("reset_stall", stall_count, 32'd0);

        // Vector table.
        for (int i = 0; i < 15; i++) begin
            step(tbl[i].iv, tbl[i].r1, tbl[i].r2, tbl[i].rd, tbl[i].rw,
                 tbl[i].wbv, tbl[i].wba, tbl[i].fl, 1'b1, gr);
            chk($sformatf("tbl%0d_ready", i), 32'(gr), 32'(tbl[i].exp_ready));
            chk($sformatf("tbl%0d_busy", i), busy_mask, tbl[i].exp_busy);
            chk($sformatf("tbl%0d_out", i), 32'(outstanding), 32'(tbl[i].exp_out));
            chk($sformatf("tbl%0d_err", i), 32'(wb_error), 32'(tbl[i].exp_err));
        end

        // Capacity: eight writes fill the scoreboard; a ninth write stalls, a read issues.
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, gr);
        for (int r = 1; r <= 8; r++) step(1, 0, 0, 5'(r), 1, 0, 0, 0, 1, gr);
        chk("cap_out", 32'(outstanding), 32'd8);
        chk("cap_busy", busy_mask, 32'h0000_01FE);
        step(1, 0, 0, 9, 1, 0, 0, 0, 1, gr);
        chk("cap_ninth_ready", 32'(gr), 32'd0);
        step(1, 10, 0, 0, 0, 0, 0, 0, 1, gr);
        chk("cap_read_ready", 32'(gr), 32'd1);
        step(1, 0, 0, 9, 1, 1, 1, 0, 1, gr);
        chk("cap_wb_free_ready", 32'(gr), 32'(BYP));

        // Mid-stream reset with pending writes, a stall and a sticky error; reset beats fire.
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, gr);
        for (int r = 1; r <= 4; r++) step(1, 0, 0, 5'(r), 1, 0, 0, 0, 1, gr);
        step(1, 1, 0, 0, 0, 0, 0, 0, 1, gr);
        step(0, 0, 0, 0, 0, 1, 0, 0, 1, gr);
        chk("pre_rst_err", 32'(wb_error), 32'd1);
        step(1, 0, 0, 9, 1, 1, 2, 0, 0, gr);
        chk("rst_ready", 32'(gr), 32'd0);
        chk("rst_busy", busy_mask, 32'd0);
        chk("rst_out", 32'(outstanding), 32'd0);
        chk("rst_stall", stall_count, 32'd0);
        chk("rst_err", 32'(wb_error), 32'd0);
        step(1, 0, 0, 9, 1, 0, 0, 0, 1, gr);
        chk("post_rst_ready", 32'(gr), 32'd1);
        chk("post_rst_busy", busy_mask, 32'h0000_0200);

        // Same-register retire and re-issue in one cycle (bypass only can fire).
        step(1, 0, 0, 7, 1, 0, 0, 0, 1, gr);
        step(1, 0, 0, 7, 1, 1, 7, 0, 1, gr);
        chk("same_reg_ready", 32'(gr), 32'(BYP));
        chk("same_reg_busy7", 32'(busy_mask[7]), 32'(BYP));
        chk("same_reg_out", 32'(outstanding), BYP ? 32'd2 : 32'd1);

        // Randomized traffic over a small register window to provoke hazards and fullness.
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, gr);
        for (int c = 0; c < 3000; c++) begin
            bit iv, rw, wbv, fl, rn;
            bit [4:0] r1, r2, rd, wba;
            iv  = ($urandom_range(0, 9) < 8);
            rw  = ($urandom_range(0, 9) < 7);
            wbv = ($urandom_range(0, 9) < 3);
            fl  = ($urandom_range(0, 39) == 0);
            rn  = ($urandom_range(0, 299) != 0);
            r1  = 5'($urandom_range(0, 13));
            r2  = 5'($urandom_range(0, 13));
            rd  = 5'($urandom_range(0, 13));
            wba = 5'($urandom_range(0, 13));
            step(iv, r1, r2, rd, rw, wbv, wba, fl, rn, gr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_issue_scoreboard

// File: doc/issue_scoreboard.md
ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

Interface
REQ-001 Parameter NUM_REGS, default 32: architectural register count.
REQ-002 Parameter REG_ADDRESS_SIZE, default 5: register address width.
REQ-003 Parameter MAX_OUTSTANDING, default 8: cap on in-flight register writes.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset (reset=0 resets on the clk edge).
REQ-006 issue_valid  input  1  decoder presents an instruction.
REQ-007 addr_r1, addr_r2, addr_rd  input  REG_ADDRESS_SIZE each  decoded source/destination addresses.
REQ-008 register_write  input  1  instruction writes addr_rd.
REQ-009 issue_ready  output  1  combinational; instruction may issue this cycle.
REQ-010 wb_valid  input  1; wb_addr  input  REG_ADDRESS_SIZE  writeback retiring a pending write.
REQ-011 flush  input  1  discard all pending state (mispredict/exception).
REQ-012 busy_mask  output  NUM_REGS  registered pending-write bits.
REQ-013 outstanding  output  clog2(MAX_OUTSTANDING+1)  registered count of set busy bits.
REQ-014 stall_count  output  32  saturating stall performance counter; wb_error  output  1  sticky spurious-writeback flag.

Function
REQ-015 Register 0 never busy; writes to rd=0 neither set busy nor count.
REQ-016 hazard = busy[r1] | busy[r2] | (register_write & busy[rd]) (RAW and WAW).
REQ-017 full = register_write & rd!=0 & outstanding==MAX_OUTSTANDING.
REQ-018 issue_ready = !hazard & !full & !flush; fire = issue_valid & issue_ready.
REQ-019 fire with register_write, rd!=0: busy[rd]<=1, outstanding+1 next cycle (latency 1).
REQ-020 wb_valid with busy[wb_addr]=1: busy[wb_addr]<=0, outstanding-1.
REQ-021 wb_valid with busy[wb_addr]=0 (incl. addr 0): state unchanged, wb_error<=1 until reset.
REQ-022 Same-cycle fire-set and wb-clear of different registers: both apply; outstanding net unchanged.
REQ-023 Same-cycle set and clear of the same register (bypass only, REQ-030): busy stays 1, outstanding unchanged.
REQ-024 stall_count +1 each cycle issue_valid & !issue_ready, including flush cycles; holds at 32'hFFFFFFFF.
REQ-025 flush: busy_mask<=0, outstanding<=0 next cycle; concurrent wb_valid ignored (no wb_error); stall_count, wb_error kept.
REQ-026 outstanding never exceeds MAX_OUTSTANDING nor underflows.

Reset
REQ-027 reset=0 at clk edge: busy_mask=0, outstanding=0, stall_count=0, wb_error=0; overrides flush, fire and wb_valid.
REQ-028 During reset issue_ready SHALL be 0; first issue possible in cycle after reset returns to 1.

Configuration
REQ-029 Macro SCOREBOARD_BYPASS_EN selects same-cycle writeback forwarding.
REQ-030 Defined: register being cleared by wb_valid this cycle counts not busy in REQ-016, and a concurrent valid clear counts as a free slot in REQ-017.
REQ-031 Undefined: REQ-016/017 use registered state only; dependent instruction issues one cycle after writeback.

Structure
REQ-032 Shared package proc_pkg holds ADDRESS_SIZE=32, REG_ADDRESS_SIZE=5, NUM_REGS=32 and the reg-address typedef, common with the decoder.
REQ-033 Single module; no sub-module is natural (busy lookup is a mux, counters inline).

Verification
REQ-034 Issue rd=3 write; next cycle r1=3 valid -> issue_ready=0, stall_count=1; wb_addr=3 -> ready next cycle (same cycle if bypass).
REQ-035 Issue 8 writes to rd=1..8 -> outstanding=8; ninth write rd=9 stalls; read-only instruction r1=10 still issues.
REQ-036 Writes with rd=0 x3 -> busy_mask=0, outstanding=0; wb_addr=0 -> wb_error=1.
REQ-037 busy rd=5,6; flush with wb_valid addr 5 -> busy_mask=0, outstanding=0, wb_error=0, issue_ready=0 that cycle.
REQ-038 reset=0 mid-stream with 4 pending -> all outputs 0 next edge; reset and fire same edge -> busy_mask=0.
REQ-039 Bypass build: rd=7 busy, wb_addr=7 and fire rd=7 same cycle -> busy[7]=1, outstanding unchanged.
